multi_reel_slot_controller: RTL
===============================

# multi_reel_slot_controller

Parametrised next-generation slot-machine game controller: N reels instead of two, configurable symbol count, credit width and timing, graded payout (full match plus partial match), and a reported win amount. Sits between the button/switch debouncers and LFSR on one side and the seven-segment/reel display drivers and LED bar on the other. All game state, wallet arithmetic and LED animation live here.

## Interface
- NUM_REELS, 3, number of reels (2..5)
- SYM_W, 3, bits per reel symbol code
- NUM_SYMBOLS, 4, symbol codes used: 0..NUM_SYMBOLS-1 (0 SEVEN, 1 CHERRY, 2 BAR, 3 QUEST)
- BET_W, 3, bet switch width; bet = sw_bet+1
- CREDIT_W, 12, wallet width
- CREDIT_MAX, 999, saturation ceiling
- START_CREDITS, 100, wallet value after reset
- LED_W, 10, LED bar width
- ANIM_DIV, 5_000_000, cycles per reel symbol advance
- LED_DIV, 2_500_000, cycles per LED chase step
- STOP_FIRST, 100_000_000, spin cycles until reel 0 stops
- STOP_STEP, 50_000_000, extra cycles per subsequent reel
- FLASH_DIV, 12_500_000, cycles per LED toggle in WIN
- FLASH_TOGGLES, 8, toggles before payout

- clk  in  1  system clock
- btn_reset  in  1  asynchronous, active-high reset
- btn_spin  in  1  debounced spin button, rising edge starts a game
- cheat_mode  in  1  forces all reels to reel 0's target
- sw_bet  in  BET_W  bet selector
- random_seed  in  NUM_REELS*SYM_W  random bits, sampled at spin start
- symbols  out  NUM_REELS*SYM_W  displayed symbol per reel, reel i at [i*SYM_W +: SYM_W]
- leds  out  LED_W  chase/flash pattern
- credits  out  CREDIT_W  wallet balance
- current_bet  out  BET_W+1  sw_bet+1, combinational
- last_win  out  CREDIT_W  credits paid by the most recent game
- busy  out  1  high outside IDLE
- no_credit  out  1  one-cycle pulse: spin refused

## Operation
- States: IDLE, SPIN, EVAL, WIN.
- IDLE: leds=0. Spin edge (btn_spin high, previous sample low) with credits >= current_bet: latch bet, credits -= bet, latch targets, clear timers, leds = MSB only, go SPIN. Otherwise on spin edge: pulse no_credit, stay.
- Target i = random_seed[i*SYM_W +: SYM_W] mod NUM_SYMBOLS; cheat_mode: all targets = target 0.
- SPIN: spin_timer increments; every ANIM_DIV cycles each still-running reel advances symbol, wrapping NUM_SYMBOLS-1 -> 0; every LED_DIV cycles leds rotate right. Reel i forced to target i when spin_timer == STOP_FIRST + i*STOP_STEP and frozen thereafter. Cycle last reel stops -> EVAL.
- EVAL (one cycle): full match (all targets equal) -> win = bet * mult(symbol), mult SEVEN 20, CHERRY 5, BAR 2, QUEST 1, others 1. Else partial match (NUM_REELS >= 3, reels 0..NUM_REELS-2 equal) -> win = bet. Else 0. last_win <= win. win>0: leds all ones, go WIN; else IDLE.
- WIN: every FLASH_DIV cycles leds <= ~leds; after FLASH_TOGGLES toggles credits <= min(credits+win, CREDIT_MAX), go IDLE.
- Arithmetic: win computed at CREDIT_W+8 bits, sum saturates; never wraps.
- btn_spin edges outside IDLE ignored (edge register still updates).

## Timing
- Reset values: symbols 0, leds 0, credits START_CREDITS, last_win 0, busy 0, no_credit 0, state IDLE.
- Reset mid-game: everything returns to reset values immediately; deducted bet is not refunded.
- Deduction visible on credits one cycle after the edge cycle; busy rises same cycle.
- Game length without win: STOP_FIRST+(NUM_REELS-1)*STOP_STEP+2 cycles from edge to IDLE.
- Payout visible the cycle WIN exits; last_win valid from EVAL+1 until next EVAL.

## Structure
- Package slot_pkg: symbol code constants, state enum, mult(symbol) function, shared by the display decoder.
- One sub-module slot_reel (per-reel animate/stop counter, instantiated NUM_REELS times via generate).

## Test plan
All with ANIM_DIV=2, LED_DIV=2, STOP_FIRST=20, STOP_STEP=10, FLASH_DIV=3, NUM_REELS=3.
- Reset, sw_bet=4, seed reels (0,0,0) -> credits 95 after edge, last_win 100, credits 195 after flashes.
- Seed (1,1,2) bet 1 -> partial match, last_win 1, credits back to 100.
- Seed (2,3,1), cheat_mode=1, bet 1 -> symbols all 2, last_win 2, credits 101.
- START_CREDITS=990, bet 8, seed (0,0,0) -> credits 982 then saturates at 999.
- Credits 3, bet 8, spin -> no_credit one cycle, state IDLE, credits 3; reset asserted mid-SPIN -> credits 100, symbols 0, busy 0 same cycle.

Source files
------------

// File: rtl/multi_reel_slot_controller_pkg.sv
// Shared slot-machine definitions: symbol codes, controller states and the
// full-match payout multiplier table (also used by the display decoder).
package slot_pkg;

  localparam int unsigned SYM_SEVEN  = 0;
  localparam int unsigned SYM_CHERRY = 1;
  localparam int unsigned SYM_BAR    = 2;
  localparam int unsigned SYM_QUEST  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_EVAL = 2'd2,
    ST_WIN  = 2'd3
  } state_t;

  function automatic logic [4:0] mult(input int unsigned sym);
    case (sym)
      SYM_SEVEN:  mult = 5'd20;
      SYM_CHERRY: mult = 5'd5;
      SYM_BAR:    mult = 5'd2;
      default:    mult = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/multi_reel_slot_controller_reel.sv
// One reel: cycles through symbols on each animation tick until its stop
// point, where it snaps to the pre-drawn target and holds until the next game.
module slot_reel #(
  parameter int unsigned SYM_W       = 3,
  parameter int unsigned NUM_SYMBOLS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             advance,
  input  logic             stop,
  input  logic [SYM_W-1:0] target,
  output logic [SYM_W-1:0] sym
);

  logic stopped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym     <= '0;
      stopped <= 1'b0;
    end else if (start) begin
      stopped <= 1'b0;
    end else if (!stopped) begin
      if (stop) begin
        sym     <= target;
        stopped <= 1'b1;
      end else if (advance) begin
        sym <= (sym == SYM_W'(NUM_SYMBOLS - 1)) ? '0 : sym + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_reel_slot_controller.sv
// N-reel slot-machine game controller: wallet, bet, reel animation/stop
// scheduling, graded payout and LED chase/flash.
module multi_reel_slot_controller
  import slot_pkg::*;
#(
  parameter int unsigned NUM_REELS     = 3,
  parameter int unsigned SYM_W         = 3,
  parameter int unsigned NUM_SYMBOLS   = 4,
  parameter int unsigned BET_W         = 3,
  parameter int unsigned CREDIT_W      = 12,
  parameter int unsigned CREDIT_MAX    = 999,
  parameter int unsigned START_CREDITS = 100,
  parameter int unsigned LED_W         = 10,
  parameter int unsigned ANIM_DIV      = 5_000_000,
  parameter int unsigned LED_DIV       = 2_500_000,
  parameter int unsigned STOP_FIRST    = 100_000_000,
  parameter int unsigned STOP_STEP     = 50_000_000,
  parameter int unsigned FLASH_DIV     = 12_500_000,
  parameter int unsigned FLASH_TOGGLES = 8
) (
  input  logic                       clk,
  input  logic                       btn_reset,
  input  logic                       btn_spin,
  input  logic                       cheat_mode,
  input  logic [BET_W-1:0]           sw_bet,
  input  logic [NUM_REELS*SYM_W-1:0] random_seed,
  output logic [NUM_REELS*SYM_W-1:0] symbols,
  output logic [LED_W-1:0]           leds,
  output logic [CREDIT_W-1:0]        credits,
  output logic [BET_W:0]             current_bet,
  output logic [CREDIT_W-1:0]        last_win,
  output logic                       busy,
  output logic                       no_credit
);

  localparam int unsigned WIN_W     = CREDIT_W + 8;
  localparam int unsigned LAST_STOP = STOP_FIRST + (NUM_REELS - 1) * STOP_STEP;
  localparam logic [WIN_W-1:0] CREDIT_ONES = WIN_W'({CREDIT_W{1'b1}});

  state_t                state;
  logic                  spin_q;
  logic                  spin_edge;
  logic                  can_play;
  logic [BET_W:0]        bet_q;
  logic [SYM_W-1:0]      seed_mod [NUM_REELS];
  logic [SYM_W-1:0]      tgt_next [NUM_REELS];
  logic [SYM_W-1:0]      tgt      [NUM_REELS];
  logic [31:0]           spin_timer, timer_next;
  logic [31:0]           anim_cnt, led_cnt, flash_cnt;
  logic [7:0]            toggle_cnt;
  logic                  anim_tick, led_tick, flash_tick;
  logic                  full_match, part_match;
  logic [WIN_W-1:0]      win_calc, win_q, pay_sum;
  logic [CREDIT_W-1:0]   payout;

  assign current_bet = {1'b0, sw_bet} + (BET_W+1)'(1);
  assign spin_edge   = btn_spin & ~spin_q;
  assign can_play    = credits >= CREDIT_W'(current_bet);
  assign busy        = (state != ST_IDLE);
  assign timer_next  = spin_timer + 32'd1;
  assign anim_tick   = (anim_cnt == 32'(ANIM_DIV - 1));
  assign led_tick    = (led_cnt == 32'(LED_DIV - 1));
  assign flash_tick  = (flash_cnt == 32'(FLASH_DIV - 1));

  // Reel stops are keyed on the next timer value so the last reel freezes on
  // the same edge that enters EVAL, giving the exact edge-to-IDLE game length.
  for (genvar i = 0; i < int'(NUM_REELS); i++) begin : g_reel
    assign seed_mod[i] = SYM_W'(32'(random_seed[i*SYM_W +: SYM_W]) % NUM_SYMBOLS);
    assign tgt_next[i] = cheat_mode ? seed_mod[0] : seed_mod[i];

    slot_reel #(
      .SYM_W       (SYM_W),
      .NUM_SYMBOLS (NUM_SYMBOLS)
    ) u_reel (
      .clk     (clk),
      .rst     (btn_reset),
      .start   (state == ST_IDLE && spin_edge && can_play),
      .advance (state == ST_SPIN && anim_tick),
      .stop    (state == ST_SPIN && timer_next == 32'(STOP_FIRST + i * STOP_STEP)),
      .target  (tgt[i]),
      .sym     (symbols[i*SYM_W +: SYM_W])
    );
  end

  always_comb begin
    full_match = 1'b1;
    part_match = (NUM_REELS >= 3);
    for (int unsigned i = 1; i < NUM_REELS; i++) begin
      if (tgt[i] != tgt[0]) full_match = 1'b0;
    end
    for (int unsigned i = 1; i < NUM_REELS - 1; i++) begin
      if (tgt[i] != tgt[0]) part_match = 1'b0;
    end
    if (full_match)
      win_calc = WIN_W'(bet_q) * WIN_W'(mult(32'(tgt[0])));
    else if (part_match)
      win_calc = WIN_W'(bet_q);
    else
      win_calc = '0;
  end

  assign pay_sum = WIN_W'(credits) + win_q;
  assign payout  = (pay_sum > WIN_W'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX) : pay_sum[CREDIT_W-1:0];

  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      state      <= ST_IDLE;
      spin_q     <= 1'b0;
      bet_q      <= '0;
      for (int unsigned i = 0; i < NUM_REELS; i++) tgt[i] <= '0;
      spin_timer <= '0;
      anim_cnt   <= '0;
      led_cnt    <= '0;
      flash_cnt  <= '0;
      toggle_cnt <= '0;
      leds       <= '0;
      credits    <= CREDIT_W'(START_CREDITS);
      last_win   <= '0;
      win_q      <= '0;
      no_credit  <= 1'b0;
    end else begin
      spin_q    <= btn_spin;
      no_credit <= 1'b0;
      case (state)
        ST_IDLE: begin
          leds <= '0;
          if (spin_edge) begin
            if (can_play) begin
              bet_q      <= current_bet;
              credits    <= credits - CREDIT_W'(current_bet);
              for (int unsigned i = 0; i < NUM_REELS; i++) tgt[i] <= tgt_next[i];
              spin_timer <= '0;
              anim_cnt   <= '0;
              led_cnt    <= '0;
              leds       <= {1'b1, {(LED_W-1){1'b0}}};
              state      <= ST_SPIN;
            end else begin
              no_credit <= 1'b1;
            end
          end
        end
        ST_SPIN: begin
          spin_timer <= timer_next;
          anim_cnt   <= anim_tick ? '0 : anim_cnt + 32'd1;
          led_cnt    <= led_tick ? '0 : led_cnt + 32'd1;
          if (led_tick) leds <= {leds[0], leds[LED_W-1:1]};
          if (timer_next == 32'(LAST_STOP)) state <= ST_EVAL;
        end
        ST_EVAL: begin
          win_q      <= win_calc;
          last_win   <= (win_calc > CREDIT_ONES) ? '1 : win_calc[CREDIT_W-1:0];
          flash_cnt  <= '0;
          toggle_cnt <= '0;
          if (win_calc != '0) begin
            leds  <= '1;
            state <= ST_WIN;
          end else begin
            leds  <= '0;
            state <= ST_IDLE;
          end
        end
        ST_WIN: begin
          if (flash_tick) begin
            flash_cnt  <= '0;
            leds       <= ~leds;
            toggle_cnt <= toggle_cnt + 8'd1;
            if (toggle_cnt == 8'(FLASH_TOGGLES - 1)) begin
              credits <= payout;
              leds    <= '0;
              state   <= ST_IDLE;
            end
          end else begin
            flash_cnt <= flash_cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
